// File: rtl/power_bank_if.sv
// power_bank control/status bundle: mode-controller requests in, reservoir status out.
interface power_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                  en;
  logic                  mode;
  logic [2*CHANNELS-1:0] setting;
  logic [1:0]            charge_rate;
  logic [WIDTH-1:0]      level;
  logic [CHANNELS-1:0]   grant;
  logic                  warn;
  logic                  full;
  logic                  locked;

  modport master (
    output en, mode, setting, charge_rate,
    input  level, grant, warn, full, locked
  );

  modport slave (
    input  en, mode, setting, charge_rate,
    output level, grant, warn, full, locked
  );
endinterface

// File: rtl/power_bank.sv
// Saturating energy reservoir with greedy priority load service, brown-out lockout and warn hysteresis.
// One-cycle update latency; no backpressure, en=0 freezes state and clears grant.
module power_bank #(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 4,
  parameter int MAX_LEVEL    = 179,
  parameter int INIT_LEVEL   = 0,
  parameter int WARN_LEVEL   = 45,
  parameter int WARN_HYST    = 5,
  parameter int RESUME_LEVEL = 60,
  parameter int CHARGE_STEP  = 1
) (
  input  logic          clk,
  input  logic          rst,
  power_bank_if.slave   bus
);

  localparam int SUMW = WIDTH + 3;
  localparam logic [WIDTH-1:0] MAX_L    = WIDTH'(MAX_LEVEL);
  localparam logic [WIDTH-1:0] INIT_L   = WIDTH'(INIT_LEVEL);
  localparam logic [WIDTH-1:0] WARN_L   = WIDTH'(WARN_LEVEL);
  localparam logic [WIDTH-1:0] RESUME_L = WIDTH'(RESUME_LEVEL);
  localparam logic [SUMW-1:0]  MAX_W    = SUMW'(MAX_LEVEL);
  localparam logic [SUMW-1:0]  CLEAR_W  = SUMW'(WARN_LEVEL + WARN_HYST);
  localparam logic [SUMW-1:0]  STEP_W   = SUMW'(CHARGE_STEP);

  typedef enum logic {NORMAL, LOCKOUT} state_t;

  state_t                stateQ, stateNext;
  logic [WIDTH-1:0]      levelQ, levelNext;
  logic [CHANNELS-1:0]   grantQ, grantNext;
  logic                  warnQ, warnNext;
  logic [SUMW-1:0]       chargeSum;
  logic [WIDTH-1:0]      rem;
  logic [1:0]            cost;
  logic                  refused;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      levelQ <= INIT_L;
      stateQ <= (INIT_LEVEL < RESUME_LEVEL) ? LOCKOUT : NORMAL;
      grantQ <= '0;
      warnQ  <= (INIT_LEVEL < WARN_LEVEL);
    end else begin
      levelQ <= levelNext;
      stateQ <= stateNext;
      grantQ <= grantNext;
      warnQ  <= warnNext;
    end
  end

  always_comb begin
    levelNext = levelQ;
    stateNext = stateQ;
    grantNext = '0;
    warnNext  = warnQ;
    chargeSum = '0;
    rem       = levelQ;
    cost      = '0;
    refused   = 1'b0;

    if (bus.en) begin
      if (!bus.mode) begin
        // Widened sum so a full-rate charge near the ceiling cannot wrap before clamping.
        chargeSum = SUMW'(levelQ) + SUMW'(bus.charge_rate) * STEP_W;
        levelNext = (chargeSum > MAX_W) ? MAX_L : chargeSum[WIDTH-1:0];
      end else if (stateQ == NORMAL) begin
        for (int i = 0; i < CHANNELS; i++) begin
          cost = bus.setting[2*i +: 2];
          if (cost != 2'd0) begin
            if (WIDTH'(cost) <= rem) begin
              grantNext[i] = 1'b1;
              rem          = rem - WIDTH'(cost);
            end else begin
              refused = 1'b1;
            end
          end
        end
        levelNext = rem;
        if (rem == '0 || refused) stateNext = LOCKOUT;
      end

      // Exit is judged on the post-update level, so a recharge edge can unlock directly.
      if (stateQ == LOCKOUT && levelNext >= RESUME_L) stateNext = NORMAL;

      if (levelNext < WARN_L)                warnNext = 1'b1;
      else if (SUMW'(levelNext) >= CLEAR_W)  warnNext = 1'b0;
    end
  end

  assign bus.level  = levelQ;
  assign bus.grant  = grantQ;
  assign bus.warn   = warnQ;
  assign bus.full   = (levelQ == MAX_L);
  assign bus.locked = (stateQ == LOCKOUT);

endmodule

// File: tb/tb_power_bank.sv
// Directed bench for power_bank: behavioural model feeds a scoreboard queue, plus fixed-value checkpoints.
module tb_power_bank;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [7:0] level;
    logic [3:0] grant;
    logic       warn;
    logic       full;
    logic       locked;
  } exp_t;

  exp_t sbQ[$];

  int   mLevel;
  logic mLocked;
  logic mWarn;
  logic [3:0] mGrant;

  power_bank_if #(.WIDTH(8), .CHANNELS(4)) bus ();

  power_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mLevel  = 0;
    mLocked = 1'b1;
    mWarn   = 1'b1;
    mGrant  = 4'b0;
  endtask

  task automatic modelStep(input logic en, input logic mode, input logic [7:0] setting, input logic [1:0] rate);
    int   rem;
    int   c;
    logic bad;
    logic wasLocked;
    wasLocked = mLocked;
    mGrant = 4'b0;
    if (en) begin
      if (!mode) begin
        mLevel = mLevel + int'(rate);
        if (mLevel > 179) mLevel = 179;
      end else if (!wasLocked) begin
        rem = mLevel;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
          c = int'(setting[2*i +: 2]);
          if (c != 0 && c <= rem) begin
            mGrant[i] = 1'b1;
            rem -= c;
          end else if (c != 0) begin
            bad = 1'b1;
          end
        end
        mLevel = rem;
        if (rem == 0 || bad) mLocked = 1'b1;
      end
      if (wasLocked && mLevel >= 60) mLocked = 1'b0;
      if (mLevel < 45) mWarn = 1'b1;
      else if (mLevel >= 50) mWarn = 1'b0;
    end
  endtask

  // Drive one update, queue the model's prediction, then compare once the DUT has registered it.
  task automatic cycle(input logic en, input logic mode, input logic [7:0] setting, input logic [1:0] rate);
    exp_t e;
    bus.en          = en;
    bus.mode        = mode;
    bus.setting     = setting;
    bus.charge_rate = rate;
    modelStep(en, mode, setting, rate);
    e.level  = 8'(mLevel);
    e.grant  = mGrant;
    e.warn   = mWarn;
    e.full   = (mLevel == 179);
    e.locked = mLocked;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    e = sbQ.pop_front();
    check("sb_level",  bus.level,  e.level);
    check("sb_grant",  bus.grant,  e.grant);
    check("sb_warn",   bus.warn,   e.warn);
    check("sb_full",   bus.full,   e.full);
    check("sb_locked", bus.locked, e.locked);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_level"},  bus.level,  0);
    check({tag, "_locked"}, bus.locked, 1);
    check({tag, "_warn"},   bus.warn,   1);
    check({tag, "_grant"},  bus.grant,  0);
    check({tag, "_full"},   bus.full,   0);
  endtask

  initial begin
    rst             = 1'b0;
    bus.en          = 1'b0;
    bus.mode        = 1'b0;
    bus.setting     = 8'h00;
    bus.charge_rate = 2'd0;
    modelReset();
    #12;
    checkReset("rst");
    @(negedge clk);
    rst = 1'b1;

    // Recharge from empty at rate 3: warn clears at 51, lockout exits at 60.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 2'd3);
      if (i == 14) check("warn_hold_45", bus.warn, 1);
      if (i == 16) begin
        check("chg_level_51", bus.level, 51);
        check("chg_warn_clear", bus.warn, 0);
      end
      if (i == 18) check("chg_locked_57", bus.locked, 1);
    end
    check("chg_level_60", bus.level, 60);
    check("chg_unlocked", bus.locked, 0);

    // Saturation at the ceiling.
    for (int i = 0; i < 39; i++) cycle(1'b1, 1'b0, 8'h00, 2'd3);
    check("sat_level_177", bus.level, 177);
    check("sat_notfull", bus.full, 0);
    cycle(1'b1, 1'b0, 8'h00, 2'd3);
    check("sat_level_179", bus.level, 179);
    check("sat_full", bus.full, 1);
    cycle(1'b1, 1'b0, 8'h00, 2'd3);
    check("sat_hold", bus.level, 179);

    // Discharge down to 4, then the greedy skip pattern.
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b1, 8'hFF, 2'd0);
    check("dis_level_11", bus.level, 11);
    check("dis_grant_all", bus.grant, 4'b1111);
    cycle(1'b1, 1'b1, 8'h1F, 2'd0);
    check("dis_level_4", bus.level, 4);
    check("dis_grant_0111", bus.grant, 4'b0111);
    check("dis_still_normal", bus.locked, 0);
    cycle(1'b1, 1'b1, 8'h5E, 2'd0);
    check("greedy_grant", bus.grant, 4'b1101);
    check("greedy_level", bus.level, 0);
    check("greedy_locked", bus.locked, 1);

    // Locked at 10: use requests are ignored.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'h00, 2'd1);
    check("lk_level_10", bus.level, 10);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 8'hFF, 2'd0);
      check("lk_hold_level", bus.level, 10);
      check("lk_hold_grant", bus.grant, 0);
      check("lk_hold_locked", bus.locked, 1);
    end

    // Warn hysteresis around 45/50.
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 8'h00, 2'd1);
    check("hy_level_60", bus.level, 60);
    check("hy_unlocked", bus.locked, 0);
    cycle(1'b1, 1'b1, 8'hFF, 2'd0);
    cycle(1'b1, 1'b1, 8'h02, 2'd0);
    check("hy_level_46", bus.level, 46);
    check("hy_warn_46", bus.warn, 0);
    cycle(1'b1, 1'b1, 8'h01, 2'd0);
    check("hy_warn_45", bus.warn, 0);
    cycle(1'b1, 1'b1, 8'h01, 2'd0);
    check("hy_level_44", bus.level, 44);
    check("hy_warn_44", bus.warn, 1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h00, 2'd1);
    check("hy_level_49", bus.level, 49);
    check("hy_warn_49", bus.warn, 1);
    cycle(1'b1, 1'b0, 8'h00, 2'd1);
    check("hy_warn_50", bus.warn, 0);

    // en low mid-discharge freezes level and clears grant.
    cycle(1'b1, 1'b1, 8'h01, 2'd0);
    cycle(1'b1, 1'b1, 8'h01, 2'd0);
    check("en_grant_pre", bus.grant, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'h01, 2'd0);
      check("en_frozen_level", bus.level, 48);
      check("en_grant_clr", bus.grant, 0);
    end
    cycle(1'b1, 1'b1, 8'h01, 2'd0);
    check("en_resume_level", bus.level, 47);

    // Asynchronous reset between edges, with a use request pending.
    bus.setting = 8'hFF;
    #3;
    rst = 1'b0;
    #1;
    modelReset();
    checkReset("arst_async");
    @(posedge clk);
    #1;
    checkReset("arst_held");
    rst = 1'b1;
    cycle(1'b1, 1'b0, 8'h00, 2'd2);
    check("post_rst_level", bus.level, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
